// File: rtl/ir_prefetch_queue_if.sv
// Fetch-side and dispatch-side signal bundle for the IR prefetch queue.
// The slave modport is the queue itself; the master modport is its environment.
interface ir_prefetch_queue_if #(
    parameter int DEPTH          = 4,
    parameter int IR_WIDTH       = 13,
    parameter int DRAM_ADDR_BITS = 9
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                      in_valid;
    logic [IR_WIDTH-1:0]       in_word;
    logic                      in_ready;
    logic                      flush;
    logic                      load_ir;
    logic                      en_io;
    logic                      en_ac;
    logic [IR_WIDTH-1:0]       ir;
    logic [3:0]                ac;
    logic [DRAM_ADDR_BITS-1:0] dram_addr;
    logic [14:0]               dram_data;
    logic [2:0]                dram_a;
    logic [2:0]                dram_b;
    logic [7:0]                dram_j;
    logic                      dispatch_valid;
    logic                      par_err;
    logic [CW-1:0]             count;

    modport slave (
        input  in_valid, in_word, flush, load_ir, en_io, en_ac, dram_data,
        output in_ready, ir, ac, dram_addr, dram_a, dram_b, dram_j,
        output dispatch_valid, par_err, count
    );

    modport master (
        output in_valid, in_word, flush, load_ir, en_io, en_ac, dram_data,
        input  in_ready, ir, ac, dram_addr, dram_a, dram_b, dram_j,
        input  dispatch_valid, par_err, count
    );
endinterface

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch FIFO feeding the IR, dispatch-RAM address formation
// and latency-matched capture of the A/B/J dispatch fields.
module ir_prefetch_queue #(
    parameter int DEPTH          = 4,
    parameter int IR_WIDTH       = 13,
    parameter int DRAM_ADDR_BITS = 9,
    parameter int DRAM_LAT       = 1
) (
    input  logic               clk,
    input  logic               reset,
    ir_prefetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [8:0] JRST = 9'o254;

    typedef enum logic [1:0] {IDLE, LOOKUP, READY} state_t;
    state_t state, state_nx;

    logic [IR_WIDTH-1:0]       fifo [DEPTH];
    logic [PW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             cnt;
    logic [1:0]                lat_cnt;
    logic [IR_WIDTH-1:0]       ir_q;
    logic [DRAM_ADDR_BITS-1:0] addr_q;
    logic [2:0]                a_q, b_q;
    logic [7:0]                j_q;
    logic                      perr_q;

    logic                full, empty, push, pop, term, io_word;
    logic [IR_WIDTH-1:0] head;
    logic [8:0]          addr_nx;
    logic [3:0]          ir_ac;
    logic [7:0]          j_nx;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign term  = (state == LOOKUP) && (lat_cnt == 2'd0);
    assign push  = bus.in_valid && !full && !bus.flush;
    assign pop   = bus.load_ir && !empty && (state != LOOKUP) && !bus.flush;
    assign head  = fifo[rd_ptr];

    // Word bit 0 is the MSB; the slices below follow that numbering.
    assign io_word = bus.en_io && (head[IR_WIDTH-1 -: 3] == 3'b111);

    always_comb begin
        addr_nx = head[IR_WIDTH-1 -: 9];
        if (io_word)
            addr_nx = {3'b111,
                       head[IR_WIDTH-8 -: 3] | {3{&head[IR_WIDTH-4 -: 4]}},
                       head[IR_WIDTH-11 -: 3]};
    end

    // JRST dispatches on its AC field instead of the low J bits.
    assign ir_ac = ir_q[IR_WIDTH-10 -: 4];
    assign j_nx  = (ir_q[IR_WIDTH-1 -: 9] == JRST) ?
                   {bus.dram_data[7:4], ir_ac} : bus.dram_data[7:0];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pop) state_nx = LOOKUP;
            LOOKUP:  if (term) state_nx = READY;
            READY: begin
                if (pop)
                    state_nx = LOOKUP;
                else if (bus.load_ir && empty)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= bus.in_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            ir_q    <= '0;
            addr_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            j_q     <= '0;
            perr_q  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            ir_q    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                ir_q    <= head;
                addr_q  <= DRAM_ADDR_BITS'(addr_nx);
                lat_cnt <= 2'(DRAM_LAT);
            end else if ((state == LOOKUP) && !term) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
            if (term) begin
                a_q <= bus.dram_data[14:12];
                b_q <= bus.dram_data[11:9];
                j_q <= j_nx;
                if (!(^bus.dram_data)) perr_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready       = !full;
    assign bus.count          = cnt;
    assign bus.ir             = ir_q;
    assign bus.ac             = bus.en_ac ? ir_ac : 4'd0;
    assign bus.dram_addr      = addr_q;
    assign bus.dram_a         = a_q;
    assign bus.dram_b         = b_q;
    assign bus.dram_j         = j_q;
    assign bus.dispatch_valid = (state == READY);
    assign bus.par_err        = perr_q;
endmodule
